pb_event_decoder: RTL
=====================

Name: pb_event_decoder

Overview:
Consumes the debounced pushbutton level and enable pulses (DPB, SCEN, MCEN, CCEN) produced by the team's pushbutton debouncer, and classifies each press into a gesture event: single click, double click, long press, or auto-repeat. Events go through a one-entry valid/ready holding register to the game controller, for example for cursor moves and cell selection. It sits between the debouncer and the Tic-Tac-Toe control FSM, one instance per button.

Parameters:
DBL_WIN, 16, double-click window in CLK cycles, counted from release detection; must be >= 2
CW, 8, gap counter width; requires 2^CW > DBL_WIN
REP_DIV, 4, REPEAT period in cycles while MCEN is held continuously high; must be >= 2

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-high reset
DPB  input  1  debounced button level
SCEN  input  1  single-cycle press-start pulse
MCEN  input  1  multi-clock enable; one-cycle pulses, then held high in continuous mode
CCEN  input  1  continuous-clock enable; observed only, not used for classification
EV_READY  input  1  consumer accepts the event this cycle
OVF_CLR  input  1  synchronous clear of EV_OVF
EV_VALID  output  1  event pending
EV_CODE  output  2  00 SINGLE, 01 DOUBLE, 10 LONG, 11 REPEAT
EV_OVF  output  1  sticky flag: an event was dropped
BUSY  output  1  high when FSM is not in IDLE

Behaviour:
- Reset values, asynchronous: state IDLE, gap counter 0, repeat counter 0, EV_VALID 0, EV_CODE 00, EV_OVF 0, BUSY 0.
- All outputs are registered. An event is generated in cycle N from the inputs sampled in cycle N, and EV_VALID/EV_CODE show it in cycle N+1.
- FSM states:
  - IDLE: SCEN=1 -> PRESS1.
  - PRESS1:
    - MCEN=1 -> emit LONG, go to HOLD. MCEN has priority over DPB=0 in the same cycle.
    - Else DPB=0 -> GAP, clear gap counter.
    - SCEN is ignored.
  - GAP: gap counter increments each cycle.
    - SCEN=1 -> emit DOUBLE, go to PRESS2.
    - Else counter==DBL_WIN-1 -> emit SINGLE, go to IDLE.
    - If SCEN arrives on the terminal cycle, DOUBLE wins.
    - SINGLE therefore appears DBL_WIN cycles after the release cycle when there is no second press.
  - PRESS2: DPB=0 -> IDLE. MCEN and SCEN are ignored (no LONG after a double click).
  - HOLD:
    - DPB=0 -> IDLE, no event. Release has priority over MCEN.
    - Otherwise, a single-cycle MCEN (previous cycle MCEN=0) -> emit REPEAT.
    - MCEN high for a 2nd consecutive cycle: clear repeat counter and enter continuous mode.
    - In continuous mode the repeat counter increments each cycle. When it reaches REP_DIV-1, emit REPEAT and wrap to 0.
    - MCEN dropping while DPB=1 leaves continuous mode and clears the repeat counter.
- Output register, one entry:
  - Accept: EV_VALID & EV_READY.
  - Load when a new event is generated and the register is empty or being accepted in the same cycle (simultaneous accept+new = load, no overflow).
  - New event while EV_VALID & !EV_READY: the new event is dropped, the held event is kept, and EV_OVF sets.
  - EV_VALID drops the cycle after an accept with no new event.
  - EV_CODE holds its last value while EV_VALID=0.
- EV_OVF: sticky. Set has priority over OVF_CLR in the same cycle; cleared only by OVF_CLR or RESET.
- BUSY = (state != IDLE), registered with the state.
- RESET mid-gesture aborts it with no event emitted. After release, a held DPB=1 with no SCEN stays in IDLE.

Optional Feature:
PB_DOUBLE_EN
- Defined: GAP and PRESS2 states exist and behave as above.
- Undefined: release in PRESS1 emits SINGLE immediately and goes to IDLE (latency 1 cycle). DOUBLE (01) is never produced, and DBL_WIN and CW are unused.

Test Plan:
- PB_DOUBLE_EN on, DBL_WIN=16: SCEN at t0, DPB low at t5, EV_READY=1 -> one SINGLE, EV_VALID high for exactly 1 cycle at t22; BUSY low from t22.
- Same build: release at t5, second SCEN at t12, release at t20 -> exactly one DOUBLE (01) at t13; no SINGLE; IDLE at t21.
- MCEN pulses at t100 and t200, then MCEN held high from t300 (REP_DIV=4), DPB falls at t321 -> LONG at t101, REPEAT at t201, continuous REPEATs at t305, t309 ... t321 (5 total); no event after t322.
- EV_READY=0 with LONG pending, then REPEAT generated -> EV_CODE stays 10, EV_OVF=1. OVF_CLR pulse -> EV_OVF=0. EV_READY with a simultaneous new REPEAT -> EV_CODE 11, EV_OVF stays 0.
- RESET asserted mid-GAP (t8 of the single-click case) -> all outputs 0 immediately, no SINGLE later. A PB_DOUBLE_EN-undefined build gives SINGLE one cycle after release.

Source files
------------

// File: rtl/pb_event_decoder.sv
// Pushbutton gesture classifier: turns debouncer level/enable pulses into SINGLE/DOUBLE/LONG/REPEAT
// events behind a one-entry valid/ready register. Define PB_DOUBLE_EN to enable double-click detection.
module pb_event_decoder #(
    parameter int DBL_WIN = 16,
    parameter int CW      = 8,
    parameter int REP_DIV = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       DPB,
    input  logic       SCEN,
    input  logic       MCEN,
    input  logic       CCEN,
    input  logic       EV_READY,
    input  logic       OVF_CLR,
    output logic       EV_VALID,
    output logic [1:0] EV_CODE,
    output logic       EV_OVF,
    output logic       BUSY
);

    localparam int RW = (REP_DIV > 2) ? $clog2(REP_DIV) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRESS1 = 3'd1;
    localparam logic [2:0] S_HOLD   = 3'd2;
`ifdef PB_DOUBLE_EN
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_PRESS2 = 3'd4;
    localparam logic [1:0] C_DOUBLE = 2'b01;
`endif

    localparam logic [1:0] C_SINGLE = 2'b00;
    localparam logic [1:0] C_LONG   = 2'b10;
    localparam logic [1:0] C_REPEAT = 2'b11;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_cnt_nxt;
    logic          mcen_q;
    logic          ev_gen;
    logic [1:0]    ev_code_gen;
    logic          unused_cfg;

`ifdef PB_DOUBLE_EN
    logic [CW-1:0] gap_cnt;
    logic [CW-1:0] gap_cnt_nxt;

    assign unused_cfg = CCEN;
`else
    assign unused_cfg = CCEN ^ (DBL_WIN > CW);
`endif

    // The repeat counter only advances while MCEN stays high inside HOLD; anything else parks it at zero.
    always_comb begin
        state_nxt   = state;
        rep_cnt_nxt = '0;
        ev_gen      = 1'b0;
        ev_code_gen = C_SINGLE;
`ifdef PB_DOUBLE_EN
        gap_cnt_nxt = gap_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (SCEN) begin
                    state_nxt = S_PRESS1;
                end
            end
            S_PRESS1: begin
                if (MCEN) begin
                    ev_gen      = 1'b1;
                    ev_code_gen = C_LONG;
                    state_nxt   = S_HOLD;
                end else if (!DPB) begin
`ifdef PB_DOUBLE_EN
                    state_nxt   = S_GAP;
                    gap_cnt_nxt = '0;
`else
                    ev_gen      = 1'b1;
                    ev_code_gen = C_SINGLE;
                    state_nxt   = S_IDLE;
`endif
                end
            end
`ifdef PB_DOUBLE_EN
            S_GAP: begin
                gap_cnt_nxt = gap_cnt + 1'b1;
                if (SCEN) begin
                    ev_gen      = 1'b1;
                    ev_code_gen = C_DOUBLE;
                    state_nxt   = S_PRESS2;
                end else if (gap_cnt == CW'(DBL_WIN - 1)) begin
                    ev_gen      = 1'b1;
                    ev_code_gen = C_SINGLE;
                    state_nxt   = S_IDLE;
                end
            end
            S_PRESS2: begin
                if (!DPB) begin
                    state_nxt = S_IDLE;
                end
            end
`endif
            S_HOLD: begin
                if (!DPB) begin
                    state_nxt = S_IDLE;
                end else if (MCEN && !mcen_q) begin
                    ev_gen      = 1'b1;
                    ev_code_gen = C_REPEAT;
                end else if (MCEN) begin
                    if (rep_cnt == RW'(REP_DIV - 1)) begin
                        ev_gen      = 1'b1;
                        ev_code_gen = C_REPEAT;
                    end else begin
                        rep_cnt_nxt = rep_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= S_IDLE;
            rep_cnt <= '0;
            mcen_q  <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            state   <= state_nxt;
            rep_cnt <= rep_cnt_nxt;
            mcen_q  <= MCEN;
            BUSY    <= (state_nxt != S_IDLE);
        end
    end

`ifdef PB_DOUBLE_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt_nxt;
        end
    end
`endif

    // A new event may replace the held one only when that one leaves this cycle; otherwise it is lost.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            EV_VALID <= 1'b0;
            EV_CODE  <= 2'b00;
            EV_OVF   <= 1'b0;
        end else begin
            if (ev_gen && (!EV_VALID || EV_READY)) begin
                EV_VALID <= 1'b1;
                EV_CODE  <= ev_code_gen;
            end else if (EV_VALID && EV_READY) begin
                EV_VALID <= 1'b0;
            end
            if (ev_gen && EV_VALID && !EV_READY) begin
                EV_OVF <= 1'b1;
            end else if (OVF_CLR) begin
                EV_OVF <= 1'b0;
            end
        end
    end

endmodule
